// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory fetch pipe.
// Holds the FSM state encoding, the fault NOP word and byte-to-word assembly.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // bytes[0] is the byte at the lowest address of the word.
  function automatic logic [31:0] assemble_word(input logic [3:0][7:0] bytes,
                                                input logic             big_endian);
    return big_endian ? {bytes[0], bytes[1], bytes[2], bytes[3]}
                      : {bytes[3], bytes[2], bytes[1], bytes[0]};
  endfunction

endpackage

// File: rtl/imem_byte_array.sv
// Byte-wide instruction storage: one synchronous write port and four
// combinational read ports, so a whole word can be gathered in one cycle.
module imem_byte_array #(
  parameter  int DEPTH_BYTES = 1024,
  localparam int IDX_W       = $clog2(DEPTH_BYTES)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [7:0]            wdata,
  input  logic [3:0][IDX_W-1:0] ridx,
  output logic [3:0][7:0]       rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  // NOTE: the array has no reset; its contents survive rst and change only
  // through the write port, which also keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) rdata[i] = mem[ridx[i]];
  end

endmodule

// File: rtl/instr_mem_pipe.sv
// Instruction fetch port over a byte-programmable memory: valid/ready request,
// optional extra access latency, held response with alignment/range fault.
module instr_mem_pipe
  import imem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0,
  parameter int BIG_ENDIAN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_instr,
  output logic              resp_fault,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data
);

  localparam int                IDX_W          = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(DEPTH_BYTES - 4);
  localparam logic [ADDR_W:0]   DEPTH_LIMIT    = (ADDR_W + 1)'(DEPTH_BYTES);
  localparam logic [3:0]        WAIT_LOAD      = 4'(WAIT_CYCLES - 1);

  state_t                  state, state_next;
  logic [3:0]              cnt, cnt_next;
  logic [ADDR_W-1:0]       addr_q;
  logic [ADDR_W-1:0]       fetch_addr;
  logic                    fetch_fault;
  logic                    capture;
  logic                    prog_hit;
  logic [3:0][IDX_W-1:0]   ridx;
  logic [3:0][7:0]         rbytes;

  assign req_ready  = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP);

  // With no wait states the word is captured on the accept edge itself,
  // before addr_q holds the request, so read straight from req_addr then.
  assign fetch_addr  = (state == IDLE) ? req_addr : addr_q;
  assign fetch_fault = (fetch_addr[1:0] != 2'b00) || (fetch_addr > LAST_WORD_ADDR);
  assign prog_hit    = prog_we && ({1'b0, prog_addr} < DEPTH_LIMIT);

  always_comb begin
    for (int i = 0; i < 4; i++) ridx[i] = fetch_addr[IDX_W-1:0] + IDX_W'(i);
  end

  imem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_array (
    .clk  (clk),
    .we   (prog_hit),
    .widx (prog_addr[IDX_W-1:0]),
    .wdata(prog_data),
    .ridx (ridx),
    .rdata(rbytes)
  );

  // NOTE: every signal gets its default before the case so no path through
  // this block leaves one unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_next = RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign capture = (state != RESP) && (state_next == RESP);

  // NOTE: non-blocking updates mean the capture below sees the array as it
  // was before this edge, so a same-cycle program write returns the old byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      resp_instr <= NOP;
      resp_fault <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (req_valid && req_ready) addr_q <= req_addr;
      if (capture) begin
        resp_fault <= fetch_fault;
        resp_instr <= fetch_fault ? NOP : assemble_word(rbytes, BIG_ENDIAN != 0);
      end
    end
  end

endmodule
